instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Holds the PC, fetches one 32-bit instruction word per step from instruction memory, presents it to
//  InstructionDecoder, then computes the next PC from Branch/Jump/JumpReg/InvZero and the ALU zero flag.
//  Sits directly upstream of the decoder; supplies pc_plus4 for jal link writes (ALUsrc = PC).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   async active-low reset
//  imem_req     out  1   fetch request, held high while in FETCH
//  imem_addr    out  32  word address = pc (valid while imem_req)
//  imem_rdata   in   32  fetched word, sampled when imem_valid
//  imem_valid   in   1   rdata valid; accepted only in FETCH, may rise in the first FETCH cycle
//  instruction  out  32  registered instruction word to decoder
//  instr_valid  out  1   instruction held and valid (state HOLD)
//  instr_ack    in   1   datapath finished this instruction; control inputs valid this cycle
//  branch       in   1   decoder Branch
//  jump         in   1   decoder Jump
//  jump_reg     in   1   decoder JumpReg
//  inv_zero     in   1   decoder InvZero (bne)
//  alu_zero     in   1   ALU zero flag
//  reg_da       in   32  register-file Da (jr target)
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (combinational)
//  misalign_err out  1   sticky: jr target not word-aligned
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, state=IDLE, instruction=0, instr_valid=0, imem_req=0,
//   misalign_err=0. Any in-flight imem_valid is ignored until the next FETCH.
//  FSM states IDLE, FETCH, HOLD, HALT:
//   IDLE : one cycle after reset release -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc. On imem_valid: instruction<=imem_rdata -> HOLD (next edge).
//   HOLD : instr_valid=1, instruction stable. instr_ack ignored outside HOLD.
//          On instr_ack: pc<=next_pc -> FETCH; if jr misaligned -> HALT instead, pc unchanged.
//   HALT : imem_req=0, instr_valid=0, misalign_err=1; left only by reset.
//  Latency: imem_valid at edge N -> instr_valid at edge N+1; ack at edge M -> imem_req with new pc after M.
//  next_pc priority (evaluated only in HOLD with instr_ack):
//   1 jump_reg : reg_da; misaligned if reg_da[1:0]!=0
//   2 jump     : {pc_plus4[31:28], instruction[25:0], 2'b00}
//   3 branch & (alu_zero ^ inv_zero) : pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}
//   4 otherwise: pc_plus4
//  Arithmetic mod 2^32; pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
//  Branch with condition false falls to pc_plus4. Simultaneous jump & branch: jump wins.
//  Reset asserted in any state: immediate return to reset values; no pc update from a pending ack.
// TESTING
//  T1 reset release, imem_valid same cycle as first req, rdata=32'h2407_000F, ack -> imem_addr 0, then 4.
//  T2 beq at pc=8, imm16=16'hFFFE, alu_zero=1 -> next pc=32'h0000_0004; alu_zero=0 -> 32'h0000_000C.
//  T3 bne (inv_zero=1, branch=1), alu_zero=0, imm16=3, pc=0x10 -> next pc=0x20.
//  T4 jal at pc=32'h4000_0000, target26=26'h0000100 -> pc=32'h4000_0400; pc_plus4=32'h4000_0004 on ack.
//  T5 jr reg_da=32'h0000_0102 -> HALT, misalign_err=1, imem_req stays 0; reset_n=0 clears, pc=RESET_PC.
//  T6 imem_valid delayed 3 cycles, reset_n pulsed mid-FETCH -> stale valid ignored, refetch from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per step and hands it to the decoder.
// Next PC comes from the jump/branch controls once the datapath acknowledges the instruction.
//
// Ports:
//   clk, reset_n           rising-edge clock, async active-low reset
//   imem_req/addr          fetch request and word address (= pc) while in FETCH
//   imem_rdata/valid       fetched word and its strobe (accepted only in FETCH)
//   instruction/instr_valid registered word to the decoder, valid while held
//   instr_ack              datapath done; control inputs are valid this cycle
//   branch/jump/jump_reg/inv_zero/alu_zero/reg_da  next-PC selection inputs
//   pc, pc_plus4           current PC and its successor
//   misalign_err           sticky flag: jr target was not word-aligned
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        inv_zero,
    input  logic        alu_zero,
    input  logic [31:0] reg_da,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_ivld;
    logic        r_merr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_next_pc;
    logic        w_take_br;
    logic        w_jr_misalign;

    assign w_pc_plus4    = r_pc + 32'd4;
    // Branch offset: sign-extended imm16, word-scaled.
    assign w_br_off      = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    // Jump target stays inside the 256 MB region of the delay-slot-free successor.
    assign w_jmp_tgt     = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    // InvZero flips the sense of the zero test, turning beq into bne.
    assign w_take_br     = branch & (alu_zero ^ inv_zero);
    assign w_jr_misalign = jump_reg & (reg_da[1:0] != 2'b00);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump_reg) begin
            w_next_pc = reg_da;
        end else if (jump) begin
            w_next_pc = w_jmp_tgt;
        end else if (w_take_br) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_req   <= 1'b0;
            r_ivld  <= 1'b0;
            r_merr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        r_instr <= imem_rdata;
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                        r_ivld  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        r_ivld <= 1'b0;
                        if (w_jr_misalign) begin
                            // Bad jr target: freeze with pc unchanged until reset.
                            r_state <= S_HALT;
                            r_merr  <= 1'b1;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= S_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    r_req  <= 1'b0;
                    r_ivld <= 1'b0;
                    r_merr <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_ivld  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign instruction  = r_instr;
    assign instr_valid  = r_ivld;
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign misalign_err = r_merr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus randomized
// fetch/ack traffic checked against a spec-level next-PC model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        inv_zero = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] reg_da = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instruction(instruction), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .branch(branch), .jump(jump),
        .jump_reg(jump_reg), .inv_zero(inv_zero), .alu_zero(alu_zero),
        .reg_da(reg_da), .pc(pc), .pc_plus4(pc_plus4),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec-level next PC: jr > j > taken branch > sequential.
    function automatic logic [31:0] ref_next(
        input logic [31:0] p, input logic [31:0] ins,
        input logic br, input logic j, input logic jr,
        input logic inv, input logic z, input logic [31:0] da);
        logic [31:0] p4;
        logic [31:0] off;
        p4 = p + 32'd4;
        off = {{16{ins[15]}}, ins[15:0]} * 32'd4;
        if (jr) return da;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        if (br && (z != inv)) return p4 + off;
        return p4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ivld", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_merr", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_pc = 32'd0;
    endtask

    task automatic do_fetch(input logic [31:0] word, input int dly);
        int k;
        k = 0;
        while (!imem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("wait_ivld", {31'd0, instr_valid}, 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        chk("ivld", {31'd0, instr_valid}, 32'd1);
        chk("instr", instruction, word);
        chk("req_off", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_ack(input logic [31:0] word, input logic br,
                          input logic j, input logic jr, input logic inv,
                          input logic z, input logic [31:0] da);
        logic [31:0] exp;
        logic bad;
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        exp = ref_next(m_pc, word, br, j, jr, inv, z, da);
        bad = jr && (da % 4 != 0);
        branch = br; jump = j; jump_reg = jr;
        inv_zero = inv; alu_zero = z; reg_da = da;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        branch = $urandom; jump = $urandom; jump_reg = $urandom;
        reg_da = $urandom;
        chk("ivld_clr", {31'd0, instr_valid}, 32'd0);
        if (bad) begin
            chk("halt_pc", pc, m_pc);
            chk("halt_merr", {31'd0, misalign_err}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
        end else begin
            chk("next_pc", pc, exp);
            chk("refetch_req", {31'd0, imem_req}, 32'd1);
            m_pc = exp;
        end
    endtask

    task automatic step(input logic [31:0] word, input logic br,
                        input logic j, input logic jr, input logic inv,
                        input logic z, input logic [31:0] da);
        do_fetch(word, $urandom_range(0, 2));
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            instr_ack = 1'b0;
            @(negedge clk);
            chk("hold_instr", instruction, word);
        end
        do_ack(word, br, j, jr, inv, z, da);
    endtask

    initial begin
        logic [31:0] w;
        logic br, j, jr;
        do_reset();
        // T1: valid in first FETCH cycle, sequential advance.
        do_fetch(32'h2407_000F, 0);
        do_ack(32'h2407_000F, 0, 0, 0, 0, 0, 0);
        chk("t1_pc4", imem_addr, 32'h4);
        step(32'h0, 0, 0, 0, 0, 0, 0);
        // T2: beq at pc 8, taken then not taken.
        step(32'h1000_FFFE, 1, 0, 0, 0, 1, 0);
        chk("t2_taken", pc, 32'h4);
        step(32'h0, 0, 0, 0, 0, 0, 0);
        step(32'h1000_FFFE, 1, 0, 0, 0, 0, 0);
        chk("t2_fall", pc, 32'hC);
        step(32'h0, 0, 0, 0, 0, 0, 0);
        // T3: bne at 0x10.
        step(32'h1400_0003, 1, 0, 0, 1, 0, 0);
        chk("t3_bne", pc, 32'h20);
        // T4: jal at 0x4000_0000, jump beats a taken branch.
        step(32'h0, 0, 0, 1, 0, 0, 32'h4000_0000);
        step(32'h0C00_0100, 1, 1, 0, 0, 1, 0);
        chk("t4_jal", pc, 32'h4000_0400);
        // Wrap from the top of the address space.
        step(32'h0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        step(32'h0, 0, 0, 0, 0, 0, 0);
        chk("wrap", pc, 32'h0);
        chk("wrap_merr", {31'd0, misalign_err}, 32'd0);
        // T5: misaligned jr halts until reset.
        step(32'h0, 0, 0, 1, 0, 0, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1;
            @(negedge clk);
            chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
            chk("halt_hold_ivld", {31'd0, instr_valid}, 32'd0);
        end
        imem_valid = 1'b0;
        do_reset();
        // T6: reset pulsed mid-FETCH with a late valid pending.
        @(negedge clk);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        imem_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        imem_valid = 1'b0;
        chk("t6_stale", {31'd0, instr_valid}, 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        m_pc = 32'd0;
        do_fetch(32'hABCD_0001, 3);
        do_ack(32'hABCD_0001, 0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            w = $urandom;
            br = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 4) == 0);
            jr = ($urandom_range(0, 5) == 0);
            step(w, br, j, jr, 1'($urandom), 1'($urandom),
                 (($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC)));
            if (misalign_err) do_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
